// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO for any depth >= 2, with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and sync flush. Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_flags #(
  parameter int Width       = 8,
  parameter int Depth       = 16,
  parameter int AlmostFull  = 14,
  parameter int AlmostEmpty = 2
) (
  input  logic                             clk_i,
  input  logic                             nrst_i,
  input  logic                             clear_i,
  input  logic                             write_i,
  input  logic [Width-1:0]                 w_data_i,
  input  logic                             read_i,
  output logic [Width-1:0]                 r_data_o,
  output logic                             r_valid_o,
  output logic                             full_flag_o,
  output logic                             empty_flag_o,
  output logic                             almost_full_o,
  output logic                             almost_empty_o,
  output logic [$clog2(Depth+1)-1:0]       count_o,
  output logic                             overflow_o,
  output logic                             underflow_o
);

  localparam int Address = $clog2(Depth);
  localparam int CountW  = $clog2(Depth+1);

  localparam logic [Address-1:0] LastPtr = Address'(Depth - 1);
  localparam logic [CountW-1:0]  DepthC  = CountW'(Depth);
  localparam logic [CountW-1:0]  AfC     = CountW'(AlmostFull);
  localparam logic [CountW-1:0]  AeC     = CountW'(AlmostEmpty);

  // Pointers wrap explicitly so non-power-of-two depths need no spare wrap bit.
  function automatic logic [Address-1:0] ptr_inc(input logic [Address-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  logic [Width-1:0]   mem_q [Depth];
  logic [Address-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0]  count_q, count_d;
  logic               empty_q, full_q, afull_q, aempty_q, ovf_q, unf_q;
  logic               empty_d, full_d, afull_d, aempty_d, ovf_d, unf_d;
  logic               rd_acc, wr_acc;

  // Accept decisions and next state; clear suppresses both requests and their error side effects.
  always_comb begin
    rd_acc   = read_i & ~empty_q & ~clear_i;
    wr_acc   = write_i & (~full_q | rd_acc) & ~clear_i;
    wr_ptr_d = wr_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd_acc ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q | (write_i & ~wr_acc);
    unf_d = unf_q | (read_i & empty_q);
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end
    empty_d  = (count_d == '0);
    full_d   = (count_d == DepthC);
    afull_d  = (count_d >= AfC);
    aempty_d = (count_d <= AeC);
  end

  always_ff @(posedge clk_i) begin
    if (wr_acc) mem_q[wr_ptr_q] <= w_data_i;
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign r_data_o  = mem_q[rd_ptr_q];
  assign r_valid_o = ~empty_q;
`else
  logic [Width-1:0] r_data_q;
  logic             r_valid_q;

  // Registered read port: data lands one cycle after the accepted read and then holds.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
    end else begin
      r_valid_q <= rd_acc;
      if (rd_acc) r_data_q <= mem_q[rd_ptr_q];
    end
  end

  assign r_data_o  = r_data_q;
  assign r_valid_o = r_valid_q;
`endif

  assign full_flag_o    = full_q;
  assign empty_flag_o   = empty_q;
  assign almost_full_o  = afull_q;
  assign almost_empty_o = aempty_q;
  assign count_o        = count_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;

endmodule
